// File: rtl/window_line_buffer_kxk.sv
// KxK sliding-window generator: raster pixels in, one KxK window out per
// valid position, stride 1/2, single output register stage with backpressure.
//
// Ports:
//   clk, rst (async, active-high)
//   frame_start, cfg_width, cfg_height, cfg_stride2 : frame setup
//   s_valid, s_ready, s_data                       : pixel stream in
//   m_valid, m_ready, m_window, m_last             : window stream out
//   frame_done                                     : final window taken
//   cfg_err                                        : illegal cfg latched
module window_line_buffer_kxk #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 3,
  parameter int MAX_WIDTH  = 64,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [CNT_W-1:0]             cfg_width,
  input  logic [CNT_W-1:0]             cfg_height,
  input  logic                         cfg_stride2,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [K*K*DATA_WIDTH-1:0]    m_window,
  output logic                         m_last,
  output logic                         frame_done,
  output logic                         cfg_err
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);
  localparam logic K_ODD = ((K % 2) == 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_w;
  logic [CNT_W-1:0]      r_h;
  logic                  r_s2;
  logic [CNT_W-1:0]      r_row;
  logic [CNT_W-1:0]      r_col;

  // r_mem[0] holds row-1, r_mem[K-2] holds row-K+1
  logic [DATA_WIDTH-1:0] r_mem [K-1][MAX_WIDTH];
  // r_win[0] is the top (oldest) row, column 0 leftmost
  logic [DATA_WIDTH-1:0] r_win [K][K];

  logic [DATA_WIDTH-1:0] w_col [K];
  logic [AW-1:0]         w_addr;
  logic                  w_acc;
  logic                  w_emit;
  logic                  w_par_ok;
  logic                  w_last_px;
  logic                  w_last_win;
  logic                  w_cfg_ok;
  logic                  w_take;
  logic [CNT_W-1:0]      w_last_row;
  logic [CNT_W-1:0]      w_last_col;

  assign s_ready = (r_state == S_RUN) && (!m_valid || m_ready);
  assign w_acc   = s_valid && s_ready;
  assign w_take  = m_valid && m_ready;
  assign w_addr  = r_col[AW-1:0];

  assign w_cfg_ok = (int'(cfg_width) >= K) &&
                    (int'(cfg_width) <= MAX_WIDTH) &&
                    (int'(cfg_height) >= K);

  // (n-K+1) even <=> n[0] differs from K's parity
  assign w_par_ok = !r_s2 ||
                    ((r_row[0] ^ K_ODD) && (r_col[0] ^ K_ODD));

  assign w_emit = w_acc && (r_row >= KM1) &&
                  (r_col >= KM1) && w_par_ok;

  // Last emitted position backs off by one when stride 2
  // leaves an odd remainder of (dim-K).
  assign w_last_row = r_h - CNT_W'(1) -
                      CNT_W'(r_s2 && (r_h[0] ^ K_ODD));
  assign w_last_col = r_w - CNT_W'(1) -
                      CNT_W'(r_s2 && (r_w[0] ^ K_ODD));

  assign w_last_win = (r_row == w_last_row) &&
                      (r_col == w_last_col);
  assign w_last_px  = (r_row == r_h - CNT_W'(1)) &&
                      (r_col == r_w - CNT_W'(1));

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      w_col[r] = r_mem[K-2-r][w_addr];
    end
    w_col[K-1] = s_data;
  end

  always_comb begin
    m_window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        m_window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[0][w_addr] <= s_data;
      for (int j = 1; j < K - 1; j++) begin
        r_mem[j][w_addr] <= r_mem[j-1][w_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_h        <= '0;
      r_s2       <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        r_w     <= cfg_width;
        r_h     <= cfg_height;
        r_s2    <= cfg_stride2;
        r_row   <= '0;
        r_col   <= '0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        cfg_err <= !w_cfg_ok;
        r_state <= w_cfg_ok ? S_RUN : S_IDLE;
      end else begin
        frame_done <= w_take && m_last;

        if (w_acc) begin
          m_valid <= w_emit;
          m_last  <= w_emit && w_last_win;
        end else if (m_ready) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end

        if (w_acc) begin
          for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
              r_win[r][c] <= r_win[r][c+1];
            end
            r_win[r][K-1] <= w_col[r];
          end
          if (r_col == r_w - CNT_W'(1)) begin
            r_col <= '0;
            r_row <= r_row + CNT_W'(1);
          end else begin
            r_col <= r_col + CNT_W'(1);
          end
        end

        case (r_state)
          S_RUN: begin
            if (w_acc && w_last_px) r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            if (!m_valid || m_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_line_buffer_kxk.sv
// Bench for window_line_buffer_kxk: K=3 and K=5 instances,
// directed frames checked against a raster-index window model.
module tb_window_line_buffer_kxk;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int MW = 64;
  localparam int WB = 25 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs3 = 1'b0;
  logic fs5 = 1'b0;
  logic [CW-1:0] cw = '0;
  logic [CW-1:0] ch = '0;
  logic cs2 = 1'b0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic m_ready = 1'b1;

  logic sr3, mv3, ml3, fd3, ce3;
  logic [9*DW-1:0] win3;
  logic sr5, mv5, ml5, fd5, ce5;
  logic [25*DW-1:0] win5;

  int sel = 0;
  logic w_sr, w_mv, w_ml, w_fd, w_ce;
  logic [WB-1:0] w_win;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int tK, tW, tH, tS, tbase;
  int n_exp, n_got, fd_cnt, fd_cyc, last_cyc;
  int acc_cnt, first_acc, last_acc, stalls;
  logic mon_en = 1'b0;
  logic held_v = 1'b0;
  logic [WB-1:0] held;
  logic rmode = 1'b0;

  window_line_buffer_kxk #(
    .DATA_WIDTH(DW), .K(3), .MAX_WIDTH(MW), .CNT_W(CW)
  ) u_k3 (
    .clk(clk), .rst(rst), .frame_start(fs3),
    .cfg_width(cw), .cfg_height(ch), .cfg_stride2(cs2),
    .s_valid(s_valid && sel == 0), .s_ready(sr3),
    .s_data(s_data), .m_valid(mv3), .m_ready(m_ready),
    .m_window(win3), .m_last(ml3), .frame_done(fd3),
    .cfg_err(ce3)
  );

  window_line_buffer_kxk #(
    .DATA_WIDTH(DW), .K(5), .MAX_WIDTH(MW), .CNT_W(CW)
  ) u_k5 (
    .clk(clk), .rst(rst), .frame_start(fs5),
    .cfg_width(cw), .cfg_height(ch), .cfg_stride2(cs2),
    .s_valid(s_valid && sel == 1), .s_ready(sr5),
    .s_data(s_data), .m_valid(mv5), .m_ready(m_ready),
    .m_window(win5), .m_last(ml5), .frame_done(fd5),
    .cfg_err(ce5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    w_sr  = sr3;
    w_mv  = mv3;
    w_ml  = ml3;
    w_fd  = fd3;
    w_ce  = ce3;
    w_win = WB'(win3);
    if (sel == 1) begin
      w_sr  = sr5;
      w_mv  = mv5;
      w_ml  = ml5;
      w_fd  = fd5;
      w_ce  = ce5;
      w_win = win5;
    end
  end

  task automatic chk(input string tag,
                     input logic [WB-1:0] got,
                     input logic [WB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WB-1:0] exp_win(input int n);
    logic [WB-1:0] v;
    int oc, tr, tc;
    v  = '0;
    oc = (tW - tK) / tS + 1;
    tr = (n / oc) * tS;
    tc = (n % oc) * tS;
    for (int r = 0; r < tK; r++)
      for (int c = 0; c < tK; c++)
        v[(r*tK+c)*DW +: DW] = DW'(tbase + (tr + r) * tW + tc + c);
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (s_valid && w_sr) begin
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
      end
      if (w_mv && held_v) chk("hold", w_win, held);
      if (w_mv && m_ready) begin
        if (n_got < n_exp) begin
          chk($sformatf("win%0d", n_got), w_win, exp_win(n_got));
          chk($sformatf("last%0d", n_got), WB'(w_ml),
              WB'(n_got == n_exp - 1));
        end else begin
          chk("win_over", WB'(n_got), WB'(n_exp - 1));
        end
        if (w_ml) last_cyc = cyc;
        n_got++;
      end
      if (w_mv && !m_ready) begin
        chk("sready_stall", WB'(w_sr), WB'(0));
        stalls++;
      end
      held_v = w_mv && !m_ready;
      held   = w_win;
      if (w_fd) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  initial begin
    int ph;
    logic [3:0] pat;
    ph  = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (rmode) m_ready = pat[ph % 4];
      else m_ready = 1'b1;
      ph++;
    end
  end

  task automatic pulse_fs(input int k);
    if (k == 5) fs5 = 1'b1;
    else fs3 = 1'b1;
    @(posedge clk);
    #1;
    fs3 = 1'b0;
    fs5 = 1'b0;
  endtask

  task automatic run_frame(input int k, input int w, input int h,
                           input int s, input int base,
                           input int npix);
    logic got;
    mon_en = 1'b0;
    sel = (k == 5) ? 1 : 0;
    cw  = CW'(w);
    ch  = CW'(h);
    cs2 = (s == 2);
    pulse_fs(k);
    tK = k; tW = w; tH = h; tS = s; tbase = base;
    n_exp = ((w - k) / s + 1) * ((h - k) / s + 1);
    n_got = 0; fd_cnt = 0; fd_cyc = -1; last_cyc = -1;
    acc_cnt = 0; first_acc = -1; last_acc = -1; stalls = 0;
    held_v = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < npix; i++) begin
      s_data  = DW'(base + i);
      s_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = w_sr;
      end
      if (!got) begin
        chk("s_ready_timeout", WB'(w_sr), WB'(1));
        break;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int t = 0; t < 200 && fd_cnt == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_nwin"}, WB'(n_got), WB'(n_exp));
    chk({tag, "_fdcnt"}, WB'(fd_cnt), WB'(1));
    chk({tag, "_fdlat"}, WB'(fd_cyc), WB'(last_cyc + 1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sready"}, WB'(w_sr), WB'(0));
    chk({tag, "_mvalid"}, WB'(w_mv), WB'(0));
    chk({tag, "_mlast"}, WB'(w_ml), WB'(0));
    chk({tag, "_fdone"}, WB'(w_fd), WB'(0));
    chk({tag, "_cfgerr"}, WB'(w_ce), WB'(0));
    chk({tag, "_window"}, w_win, WB'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst3");
    chk("rst5_mvalid", WB'(mv5), WB'(0));
    chk("rst5_sready", WB'(sr5), WB'(0));
    chk("rst5_window", WB'(win5), WB'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(3, 5, 5, 1, 0, 25);
    finish_frame("s1");
    chk("s1_nogap", WB'(last_acc - first_acc), WB'(24));

    run_frame(3, 7, 7, 2, 1000, 49);
    finish_frame("s2");

    rmode = 1'b1;
    run_frame(3, 5, 5, 1, 2000, 25);
    finish_frame("stall");
    chk("stall_seen", WB'(stalls > 0), WB'(1));
    rmode = 1'b0;

    run_frame(5, 8, 6, 1, 3000, 48);
    finish_frame("k5");

    run_frame(3, 5, 5, 1, 4000, 12);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(3, 5, 5, 1, 5000, 25);
    finish_frame("afterrst");

    mon_en = 1'b0;
    sel = 0;
    cw = CW'(2);
    ch = CW'(5);
    cs2 = 1'b0;
    pulse_fs(3);
    @(negedge clk);
    chk("cfgerr_set", WB'(w_ce), WB'(1));
    seen = 0;
    s_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (w_sr || w_mv) seen++;
    end
    s_valid = 1'b0;
    chk("cfgerr_quiet", WB'(seen), WB'(0));
    cw = CW'(5);
    pulse_fs(3);
    @(negedge clk);
    chk("cfgerr_clr", WB'(w_ce), WB'(0));
    chk("cfgerr_run", WB'(w_sr), WB'(1));
    @(posedge clk);
    #1;

    run_frame(3, 5, 5, 1, 6000, 14);
    run_frame(3, 5, 5, 1, 7000, 25);
    finish_frame("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
